// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: step prescaler, side-select debounce, hazard/turn/idle
// arbitration, sweep/flash FSM and registered per-side lamp decode.

module tail_light_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1, s2, acc;
  logic [CW-1:0] cnt;

  // press is a one-cycle pulse on an accepted 1->0 of the synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      acc   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= sel_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == acc) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        acc   <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module tail_light_lamp #(
  parameter bit INNER_MSB = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] level,
  input  logic       sweep,
  input  logic       haz,
  input  logic       flash_on,
  input  logic       brake,
  input  logic       active,
  output logic [2:0] lamp
);
  logic [2:0] fill, pat;

  always_comb begin
    case (level)
      2'd1:    fill = 3'b001;
      2'd2:    fill = 3'b011;
      2'd3:    fill = 3'b111;
      default: fill = 3'b000;
    endcase
    // right group fills from its MSB (innermost) outward
    pat = INNER_MSB ? {fill[0], fill[1], fill[2]} : fill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              lamp <= 3'b000;
    else if (haz)            lamp <= flash_on ? 3'b111 : 3'b000;
    else if (sweep && active) lamp <= pat;
    else                     lamp <= brake ? 3'b111 : 3'b000;
  end
endmodule

module tail_light_sequencer #(
  parameter int TICK_DIV = 5_000_000,
  parameter int DEBOUNCE = 16
) (
  input  logic       ADC_CLK_10,
  input  logic       reset_n,
  input  logic       sel_n,
  input  logic       hazard,
  input  logic       turn_en,
  input  logic       brake,
  output logic [2:0] left_led,
  output logic [2:0] right_led,
  output logic       side
);
  localparam int PW        = $clog2(TICK_DIV);
  localparam int NUM_SIDES = 2;

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_HON, S_HOFF} state_t;
  typedef enum logic [1:0] {M_IDLE, M_TURN, M_HAZ} mode_t;

  state_t        state;
  mode_t         mode, mode_q;
  logic [PW-1:0] pcnt;
  logic          tick, press, brake_q;
  logic [1:0]    level;
  logic          sweep, haz, flash_on;

  tail_light_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk   (ADC_CLK_10),
    .rst_n (reset_n),
    .sel_n (sel_n),
    .press (press)
  );

  always_comb begin
    mode = M_IDLE;
    if (hazard)       mode = M_HAZ;
    else if (turn_en) mode = M_TURN;
  end

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  // mode entry and side restarts realign the prescaler so every step lasts TICK_DIV
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      mode_q  <= M_IDLE;
      pcnt    <= '0;
      side    <= 1'b0;
      brake_q <= 1'b0;
    end else begin
      brake_q <= brake;
      if (press) side <= ~side;
      if (mode != mode_q) begin
        mode_q <= mode;
        pcnt   <= '0;
        case (mode)
          M_HAZ:   state <= S_HON;
          M_TURN:  state <= S_T1;
          default: state <= S_IDLE;
        endcase
      end else if (press && mode == M_TURN) begin
        pcnt  <= '0;
        state <= S_T1;
      end else begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tick) begin
          case (state)
            S_T0:    state <= S_T1;
            S_T1:    state <= S_T2;
            S_T2:    state <= S_T3;
            S_T3:    state <= S_T0;
            S_HON:   state <= S_HOFF;
            S_HOFF:  state <= S_HON;
            default: state <= state;
          endcase
        end
      end
    end
  end

  always_comb begin
    level    = 2'd0;
    sweep    = 1'b0;
    haz      = 1'b0;
    flash_on = 1'b0;
    case (state)
      S_T0:    sweep = 1'b1;
      S_T1:    begin sweep = 1'b1; level = 2'd1; end
      S_T2:    begin sweep = 1'b1; level = 2'd2; end
      S_T3:    begin sweep = 1'b1; level = 2'd3; end
      S_HON:   begin haz = 1'b1; flash_on = 1'b1; end
      S_HOFF:  haz = 1'b1;
      default: ;
    endcase
  end

  logic [NUM_SIDES-1:0][2:0] lamp;

  for (genvar i = 0; i < NUM_SIDES; i++) begin : g_side
    tail_light_lamp #(.INNER_MSB(i == 1)) u_lamp (
      .clk      (ADC_CLK_10),
      .rst_n    (reset_n),
      .level    (level),
      .sweep    (sweep),
      .haz      (haz),
      .flash_on (flash_on),
      .brake    (brake_q),
      .active   (side == (i == 1)),
      .lamp     (lamp[i])
    );
  end

  assign left_led  = lamp[0];
  assign right_led = lamp[1];
endmodule
